// File: rtl/avr_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, requester IDs
// and the default memory geometry.
package avr_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

  localparam int unsigned MEM_AW_DEFAULT   = 11;
  localparam int unsigned MAX_WAIT_DEFAULT = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. Bit index of req_i/gnt_o is the requester ID.
// A single requester always wins; on contention the one not granted last wins.
module rr_arb2
  import avr_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic       dma_only_i,
  input  logic       set_last_dma_i,
  output logic [1:0] gnt_o
);

  req_id_e last_grant_q, last_grant_d;

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    gnt_o = 2'b00;
    if (dma_only_i) begin
      gnt_o[REQ_DMA] = req_i[REQ_DMA];
    end else if (req_i == 2'b11) begin
      gnt_o = (last_grant_q == REQ_DMA) ? 2'b01 : 2'b10;
    end else begin
      gnt_o = req_i;
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (set_last_dma_i || gnt_o[REQ_DMA]) begin
      last_grant_d = REQ_DMA;
    end else if (gnt_o[REQ_CPU]) begin
      last_grant_d = REQ_CPU;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= REQ_DMA;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// CPU/DMA arbiter for a single-port byte-wide data memory: combinational
// grant, one access per cycle, read data returned one cycle after the grant.
module data_mem_arbiter
  import avr_pkg::*;
#(
  parameter int unsigned MEM_AW   = MEM_AW_DEFAULT,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [15:0]       cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_rvalid,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [15:0]       dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic [7:0]        dma_rdata,
  output logic              dma_rvalid,
  output logic              dma_gnt,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic              addr_err
);

  localparam int unsigned    WCW        = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  arb_state_e        state_q, state_d;
  logic [WCW-1:0]    wait_cnt_q, wait_cnt_d, wait_inc;
  logic [1:0]        req, gnt;
  logic              dma_only, set_last_dma;
  logic              cpu_granted, dma_granted, any_gnt;
  logic [15:0]       sel_addr;
  logic              sel_we, sel_oob;
  logic [7:0]        sel_wdata;
  logic [MEM_AW-1:0] mem_addr_q;
  logic              cpu_rv_q, dma_rv_q, oob_q;

  // Nothing is granted while in reset, so no read can be in flight afterwards.
  assign req = {dma_req, cpu_req} & {2{~RST}};

  rr_arb2 u_rr_arb2 (
    .clk           (CLK),
    .rst           (RST),
    .req_i         (req),
    .dma_only_i    (dma_only),
    .set_last_dma_i(set_last_dma),
    .gnt_o         (gnt)
  );

  assign cpu_granted = gnt[REQ_CPU];
  assign dma_granted = gnt[REQ_DMA];
  assign any_gnt     = cpu_granted | dma_granted;

  always_comb begin
    sel_addr  = cpu_addr;
    sel_we    = cpu_we;
    sel_wdata = cpu_wdata;
    if (dma_granted) begin
      sel_addr  = dma_addr;
      sel_we    = dma_we;
      sel_wdata = dma_wdata;
    end
  end

  assign sel_oob   = (sel_addr >> MEM_AW) != 16'd0;
  assign mem_addr  = any_gnt ? sel_addr[MEM_AW-1:0] : mem_addr_q;
  assign mem_we    = any_gnt & sel_we & ~sel_oob;
  assign mem_wdata = any_gnt ? sel_wdata : 8'h00;

  assign wait_inc = wait_cnt_q + WCW'(cpu_req);

  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = '0;
    dma_only     = 1'b0;
    set_last_dma = 1'b0;
    case (state_q)
      ARB: begin
        if (dma_granted && dma_lock) begin
          // The locking grant itself is the first cycle a requesting CPU waits.
          wait_cnt_d = WCW'(cpu_req);
          if (wait_cnt_d == WAIT_LIMIT) begin
            set_last_dma = 1'b1;
          end else begin
            state_d = LOCK;
          end
        end
      end
      LOCK: begin
        dma_only = 1'b1;
        if (wait_inc == WAIT_LIMIT) begin
          state_d      = ARB;
          set_last_dma = 1'b1;
        end else if (!dma_req || !dma_lock) begin
          state_d = ARB;
        end else begin
          wait_cnt_d = wait_inc;
        end
      end
      default: state_d = ARB;
    endcase
  end

  // NOTE: mem_addr_q is a plain register, not storage, so it is reset for a clean idle bus.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ARB;
      wait_cnt_q <= '0;
      mem_addr_q <= '0;
      cpu_rv_q   <= 1'b0;
      dma_rv_q   <= 1'b0;
      oob_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (any_gnt) begin
        mem_addr_q <= sel_addr[MEM_AW-1:0];
      end
      cpu_rv_q <= cpu_granted & ~cpu_we;
      dma_rv_q <= dma_granted & ~dma_we;
      oob_q    <= any_gnt & sel_oob;
    end
  end

  assign cpu_rvalid = cpu_rv_q & ~RST;
  assign dma_rvalid = dma_rv_q & ~RST;
  assign addr_err   = oob_q & ~RST;
  assign cpu_rdata  = (cpu_rvalid & ~oob_q) ? mem_rdata : 8'h00;
  assign dma_rdata  = (dma_rvalid & ~oob_q) ? mem_rdata : 8'h00;
  assign cpu_stall  = cpu_req & ~cpu_granted & ~RST;
  assign dma_gnt    = dma_granted;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural 2 KiB memory that
// writes on posedge and reads from the address sampled at the previous posedge.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, dma_req, dma_we, dma_lock;
  logic [15:0] cpu_addr, dma_addr;
  logic [7:0]  cpu_wdata, dma_wdata, cpu_rdata, dma_rdata;
  logic        cpu_rvalid, cpu_stall, dma_rvalid, dma_gnt;
  logic [10:0] mem_addr;
  logic        mem_we, addr_err;
  logic [7:0]  mem_wdata, mem_rdata;

  logic [7:0]  mem [0:2047];
  logic [10:0] raddr_q = '0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  data_mem_arbiter #(.MEM_AW(11), .MAX_WAIT(8)) dut (
    .CLK       (clk),
    .RST       (rst),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_rvalid(cpu_rvalid),
    .cpu_stall (cpu_stall),
    .dma_req   (dma_req),
    .dma_we    (dma_we),
    .dma_lock  (dma_lock),
    .dma_addr  (dma_addr),
    .dma_wdata (dma_wdata),
    .dma_rdata (dma_rdata),
    .dma_rvalid(dma_rvalid),
    .dma_gnt   (dma_gnt),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .addr_err  (addr_err)
  );

  // Memory contents are reloaded during reset so every test starts from the same image.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
      mem[11'h010] <= 8'hA5;
      mem[11'h020] <= 8'h5A;
      mem[11'h100] <= 8'h11;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
    raddr_q <= mem_addr;
  end
  assign mem_rdata = mem[raddr_q];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 8'h00;
    dma_lock = 1'b0;
  endtask

  task automatic cpu_rd(input logic [15:0] a);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic dma_rd(input logic [15:0] a);
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = a;
  endtask

  task automatic dma_wr(input logic [15:0] a, input logic [7:0] d);
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = a; dma_wdata = d;
  endtask

  initial begin
    // Reset with a CPU read requested throughout: every output must stay low.
    rst = 1'b1;
    idle();
    cpu_rd(16'h0010);
    tick();
    check("rst_cpu_stall", cpu_stall, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_dma_gnt", dma_gnt, 1'b0);
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_dma_rvalid", dma_rvalid, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);
    check("rst_mem_addr", mem_addr, 11'h000);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("post_rst_squash", cpu_rvalid, 1'b0);

    // Single CPU read: data one cycle after the grant, no stall.
    cpu_rd(16'h0010);
    #1;
    check("rd_stall", cpu_stall, 1'b0);
    check("rd_mem_addr", mem_addr, 11'h010);
    check("rd_mem_we", mem_we, 1'b0);
    tick();
    idle();
    #1;
    check("rd_rvalid", cpu_rvalid, 1'b1);
    check("rd_rdata", cpu_rdata, 8'hA5);
    check("idle_addr_hold", mem_addr, 11'h010);
    check("idle_mem_we", mem_we, 1'b0);
    tick();
    check("rd_rvalid_once", cpu_rvalid, 1'b0);

    // Reset arriving right after a granted read hides its rvalid.
    cpu_rd(16'h0010);
    tick();
    rst = 1'b1;
    idle();
    #1;
    check("midrst_rvalid", cpu_rvalid, 1'b0);
    check("midrst_rdata", cpu_rdata, 8'h00);
    tick();
    rst = 1'b0;

    // Continuous contention after reset alternates CPU, DMA, CPU, DMA.
    cpu_rd(16'h0010);
    dma_rd(16'h0020);
    #1;
    check("rr1_stall", cpu_stall, 1'b0);
    check("rr1_dma_gnt", dma_gnt, 1'b0);
    check("rr1_mem_addr", mem_addr, 11'h010);
    tick();
    check("rr2_cpu_rvalid", cpu_rvalid, 1'b1);
    check("rr2_cpu_rdata", cpu_rdata, 8'hA5);
    check("rr2_dma_rvalid", dma_rvalid, 1'b0);
    check("rr2_stall", cpu_stall, 1'b1);
    check("rr2_dma_gnt", dma_gnt, 1'b1);
    check("rr2_mem_addr", mem_addr, 11'h020);
    tick();
    check("rr3_dma_rvalid", dma_rvalid, 1'b1);
    check("rr3_dma_rdata", dma_rdata, 8'h5A);
    check("rr3_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rr3_stall", cpu_stall, 1'b0);
    check("rr3_dma_gnt", dma_gnt, 1'b0);
    tick();
    check("rr4_cpu_rvalid", cpu_rvalid, 1'b1);
    check("rr4_stall", cpu_stall, 1'b1);
    check("rr4_dma_gnt", dma_gnt, 1'b1);
    tick();
    idle();
    #1;
    check("rr5_dma_rvalid", dma_rvalid, 1'b1);
    check("rr5_dma_rdata", dma_rdata, 8'h5A);

    // CPU write then DMA read of the same address returns the new byte.
    cpu_wr(16'h0030, 8'h77);
    #1;
    check("wr_mem_we", mem_we, 1'b1);
    check("wr_mem_wdata", mem_wdata, 8'h77);
    check("wr_stall", cpu_stall, 1'b0);
    tick();
    idle();
    dma_rd(16'h0030);
    #1;
    check("wr_no_rvalid", cpu_rvalid, 1'b0);
    check("raw_dma_gnt", dma_gnt, 1'b1);
    check("raw_mem_we", mem_we, 1'b0);
    tick();
    idle();
    #1;
    check("raw_dma_rvalid", dma_rvalid, 1'b1);
    check("raw_dma_rdata", dma_rdata, 8'h77);

    // Out-of-range DMA write is granted but never reaches memory.
    dma_wr(16'h0900, 8'hEE);
    #1;
    check("oob_wr_gnt", dma_gnt, 1'b1);
    check("oob_wr_mem_we", mem_we, 1'b0);
    check("oob_wr_mem_addr", mem_addr, 11'h100);
    tick();
    idle();
    #1;
    check("oob_wr_err", addr_err, 1'b1);
    check("oob_wr_no_rvalid", dma_rvalid, 1'b0);
    check("oob_wr_mem_intact", mem[11'h100], 8'h11);

    // Out-of-range CPU read returns zero even though the aliased byte is 0xA5.
    cpu_rd(16'hF010);
    #1;
    check("oob_rd_stall", cpu_stall, 1'b0);
    tick();
    idle();
    #1;
    check("oob_rd_rvalid", cpu_rvalid, 1'b1);
    check("oob_rd_rdata", cpu_rdata, 8'h00);
    check("oob_rd_err", addr_err, 1'b1);
    tick();
    check("oob_err_once", addr_err, 1'b0);

    // Locked DMA against a waiting CPU: 8 DMA grants, then the CPU gets in.
    cpu_rd(16'h0010);
    dma_rd(16'h0020);
    dma_lock = 1'b1;
    #1;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("lock%0d_dma_gnt", k), dma_gnt, 1'b1);
      check($sformatf("lock%0d_stall", k), cpu_stall, 1'b1);
      if (k > 1) begin
        check($sformatf("lock%0d_dma_rdata", k), {dma_rvalid, dma_rdata}, {1'b1, 8'h5A});
      end
      tick();
    end
    check("starve_dma_gnt", dma_gnt, 1'b0);
    check("starve_stall", cpu_stall, 1'b0);
    check("starve_mem_addr", mem_addr, 11'h010);
    check("starve_dma_rvalid", dma_rvalid, 1'b1);
    tick();
    check("relock_cpu_rdata", {cpu_rvalid, cpu_rdata}, {1'b1, 8'hA5});
    check("relock_dma_gnt", dma_gnt, 1'b1);
    tick();
    dma_lock = 1'b0;
    #1;
    check("unlock_dma_gnt", dma_gnt, 1'b1);
    check("unlock_stall", cpu_stall, 1'b1);
    tick();
    check("arb_back_stall", cpu_stall, 1'b0);
    check("arb_back_dma_gnt", dma_gnt, 1'b0);
    tick();
    idle();
    #1;
    check("final_cpu_rvalid", cpu_rvalid, 1'b1);
    check("final_addr_hold", mem_addr, 11'h010);
    check("final_mem_we", mem_we, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
